// File: rtl/dram_rsp_queue.sv
// In-order DRAM read-beat queue with a burst-length tracker that numbers beats and flags burst completion.
// Optional feature macro DRAM_RSP_BYPASS_EN: a tracked beat arriving at an empty, unstalled queue is delivered in the same cycle.
module dram_rsp_queue #(
  parameter int RSP_DEPTH     = 8,
  parameter int MAX_BURSTS    = 4,
  parameter int DRAM_ID_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     rd_issue,
  input  logic [2:0]               rd_issue_num,
  input  logic                     dram_rsp_valid,
  input  logic [DRAM_ID_WIDTH-1:0] dram_rsp_id,
  input  logic [DATA_WIDTH-1:0]    dram_rsp_rdata,
  output logic                     dram_rsp_ready,
  input  logic                     be_stall,
  output logic                     sram_res_valid,
  output logic [DATA_WIDTH-1:0]    sram_rdata,
  output logic [DRAM_ID_WIDTH-1:0] rsp_id,
  output logic [2:0]               rsp_sub_id,
  output logic                     burst_complete,
  output logic                     be_dram_rd_req_complete,
  output logic                     rsp_queue_full,
  output logic                     burst_track_full,
  output logic                     rsp_err
);

  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int TAW = $clog2(MAX_BURSTS);
  localparam int EW  = DRAM_ID_WIDTH + DATA_WIDTH;

  logic [EW-1:0]  rsp_mem_q [RSP_DEPTH];
  logic [2:0]     trk_mem_q [MAX_BURSTS];
  logic [RAW:0]   rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [TAW:0]   trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           err_q, err_d;

  logic           rsp_empty_s, rsp_full_s, trk_empty_s, trk_full_s;
  logic           accept_s, tracked_s, bypass_s, rsp_push_s, rsp_pop_s;
  logic           deliver_s, last_beat_s, issue_ok_s, issue_bad_s;
  logic [EW-1:0]  head_s;
  logic [2:0]     head_len_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign rsp_empty_s = (rsp_wr_q == rsp_rd_q);
  assign rsp_full_s  = (rsp_wr_q[RAW] != rsp_rd_q[RAW]) &&
                       (rsp_wr_q[RAW-1:0] == rsp_rd_q[RAW-1:0]);
  assign trk_empty_s = (trk_wr_q == trk_rd_q);
  assign trk_full_s  = (trk_wr_q[TAW] != trk_rd_q[TAW]) &&
                       (trk_wr_q[TAW-1:0] == trk_rd_q[TAW-1:0]);
  assign head_s      = rsp_mem_q[rsp_rd_q[RAW-1:0]];
  assign head_len_s  = trk_mem_q[trk_rd_q[TAW-1:0]];

  // Handshake, delivery decision and burst bookkeeping for this cycle.
  always_comb begin
    accept_s    = dram_rsp_valid && !rsp_full_s;
    tracked_s   = accept_s && !trk_empty_s;
`ifdef DRAM_RSP_BYPASS_EN
    bypass_s    = tracked_s && rsp_empty_s && !be_stall;
`else
    bypass_s    = 1'b0;
`endif
    rsp_push_s  = tracked_s && !bypass_s;
    rsp_pop_s   = !rsp_empty_s && !be_stall;
    deliver_s   = rsp_pop_s || bypass_s;
    last_beat_s = deliver_s && !trk_empty_s && (cnt_q == (head_len_s - 3'd1));
    issue_ok_s  = rd_issue && (rd_issue_num != 3'd0) && !trk_full_s;
    issue_bad_s = rd_issue && !issue_ok_s;
  end

  // Next-state values for pointers, beat counter and the sticky error.
  always_comb begin
    rsp_wr_d = rsp_push_s  ? (rsp_wr_q + {{RAW{1'b0}}, 1'b1}) : rsp_wr_q;
    rsp_rd_d = rsp_pop_s   ? (rsp_rd_q + {{RAW{1'b0}}, 1'b1}) : rsp_rd_q;
    trk_wr_d = issue_ok_s  ? (trk_wr_q + {{TAW{1'b0}}, 1'b1}) : trk_wr_q;
    trk_rd_d = last_beat_s ? (trk_rd_q + {{TAW{1'b0}}, 1'b1}) : trk_rd_q;
    if (last_beat_s) begin
      cnt_d = 3'd0;
    end else if (deliver_s) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
    err_d = err_q || issue_bad_s || (accept_s && trk_empty_s);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_wr_q <= {(RAW+1){1'b0}};
      rsp_rd_q <= {(RAW+1){1'b0}};
      trk_wr_q <= {(TAW+1){1'b0}};
      trk_rd_q <= {(TAW+1){1'b0}};
      cnt_q    <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      rsp_wr_q <= rsp_wr_d;
      rsp_rd_q <= rsp_rd_d;
      trk_wr_q <= trk_wr_d;
      trk_rd_q <= trk_rd_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage arrays; contents only matter between the read and write pointers.
  always_ff @(posedge clk) begin
    if (rsp_push_s) begin
      rsp_mem_q[rsp_wr_q[RAW-1:0]] <= {dram_rsp_id, dram_rsp_rdata};
    end
    if (issue_ok_s) begin
      trk_mem_q[trk_wr_q[TAW-1:0]] <= rd_issue_num;
    end
  end

  // Delivered beat view; zero while nothing is available so reset shows zeros.
  always_comb begin
    if (!rsp_empty_s) begin
      {rsp_id, sram_rdata} = head_s;
`ifdef DRAM_RSP_BYPASS_EN
    end else if (bypass_s) begin
      {rsp_id, sram_rdata} = {dram_rsp_id, dram_rsp_rdata};
`endif
    end else begin
      {rsp_id, sram_rdata} = {EW{1'b0}};
    end
  end

  assign dram_rsp_ready          = !rsp_full_s;
  assign sram_res_valid          = deliver_s;
  assign rsp_sub_id              = cnt_q;
  assign burst_complete          = last_beat_s;
  assign be_dram_rd_req_complete = trk_empty_s && rsp_empty_s;
  assign rsp_queue_full          = rsp_full_s;
  assign burst_track_full        = trk_full_s;
  assign rsp_err                 = err_q;

endmodule

// File: tb/tb_dram_rsp_queue.sv
// Self-checking bench for dram_rsp_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_dram_rsp_queue;
  localparam int RSP_DEPTH  = 8;
  localparam int MAX_BURSTS = 4;
`ifdef DRAM_RSP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst, rd_issue, dram_rsp_valid, be_stall;
  logic [2:0]  rd_issue_num;
  logic [7:0]  dram_rsp_id;
  logic [31:0] dram_rsp_rdata;
  logic        dram_rsp_ready, sram_res_valid, burst_complete;
  logic        be_dram_rd_req_complete, rsp_queue_full, burst_track_full, rsp_err;
  logic [31:0] sram_rdata;
  logic [7:0]  rsp_id;
  logic [2:0]  rsp_sub_id;

  int checks = 0;
  int failures = 0;

  dram_rsp_queue #(.RSP_DEPTH(RSP_DEPTH), .MAX_BURSTS(MAX_BURSTS),
                   .DRAM_ID_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .n_rst(n_rst), .rd_issue(rd_issue), .rd_issue_num(rd_issue_num),
    .dram_rsp_valid(dram_rsp_valid), .dram_rsp_id(dram_rsp_id),
    .dram_rsp_rdata(dram_rsp_rdata), .dram_rsp_ready(dram_rsp_ready),
    .be_stall(be_stall), .sram_res_valid(sram_res_valid), .sram_rdata(sram_rdata),
    .rsp_id(rsp_id), .rsp_sub_id(rsp_sub_id), .burst_complete(burst_complete),
    .be_dram_rd_req_complete(be_dram_rd_req_complete),
    .rsp_queue_full(rsp_queue_full), .burst_track_full(burst_track_full),
    .rsp_err(rsp_err));

  always #5 clk = ~clk;

  // Reference model: beats waiting for delivery, outstanding burst lengths, beat index, error.
  logic [39:0] mq[$];
  int          tq[$];
  int          mcnt = 0;
  bit          merr = 1'b0;
  bit          mon_en = 1'b1;
  bit          e_full, e_acc, e_trk, e_byp, e_pop, e_dlv, e_last, e_drop, e_tfull;
  logic [39:0] e_head;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!n_rst) begin
        mq.delete(); tq.delete(); mcnt = 0; merr = 1'b0;
      end
      e_full  = (mq.size() == RSP_DEPTH);
      e_tfull = (tq.size() == MAX_BURSTS);
      e_acc   = dram_rsp_valid && !e_full;
      e_trk   = e_acc && (tq.size() > 0);
      e_drop  = e_acc && (tq.size() == 0);
      e_byp   = BYP && e_trk && (mq.size() == 0) && !be_stall;
      e_pop   = (mq.size() > 0) && !be_stall;
      e_dlv   = e_pop || e_byp;
      e_head  = (mq.size() > 0) ? mq[0] : (e_byp ? {dram_rsp_id, dram_rsp_rdata} : 40'd0);
      e_last  = e_dlv && (tq.size() > 0) && (mcnt == tq[0] - 1);
      checks += 10;
      if (sram_res_valid !== e_dlv) begin failures++; $display("FAIL mon_valid t=%0t got=%0b exp=%0b", $time, sram_res_valid, e_dlv); end
      if (sram_rdata !== e_head[31:0]) begin failures++; $display("FAIL mon_rdata t=%0t got=%h exp=%h", $time, sram_rdata, e_head[31:0]); end
      if (rsp_id !== e_head[39:32]) begin failures++; $display("FAIL mon_id t=%0t got=%h exp=%h", $time, rsp_id, e_head[39:32]); end
      if (rsp_sub_id !== 3'(mcnt)) begin failures++; $display("FAIL mon_sub_id t=%0t got=%0d exp=%0d", $time, rsp_sub_id, mcnt); end
      if (burst_complete !== e_last) begin failures++; $display("FAIL mon_burst_complete t=%0t got=%0b exp=%0b", $time, burst_complete, e_last); end
      if (dram_rsp_ready !== !e_full) begin failures++; $display("FAIL mon_ready t=%0t got=%0b exp=%0b", $time, dram_rsp_ready, !e_full); end
      if (rsp_queue_full !== e_full) begin failures++; $display("FAIL mon_qfull t=%0t got=%0b exp=%0b", $time, rsp_queue_full, e_full); end
      if (burst_track_full !== e_tfull) begin failures++; $display("FAIL mon_tfull t=%0t got=%0b exp=%0b", $time, burst_track_full, e_tfull); end
      if (be_dram_rd_req_complete !== (mq.size() == 0 && tq.size() == 0)) begin failures++; $display("FAIL mon_complete t=%0t got=%0b", $time, be_dram_rd_req_complete); end
      if (rsp_err !== merr) begin failures++; $display("FAIL mon_err t=%0t got=%0b exp=%0b", $time, rsp_err, merr); end
      if (n_rst) begin
        if (e_pop) void'(mq.pop_front());
        if (e_trk && !e_byp) mq.push_back({dram_rsp_id, dram_rsp_rdata});
        if (e_last) begin
          void'(tq.pop_front());
          mcnt = 0;
        end else if (e_dlv) begin
          mcnt = (mcnt + 1) % 8;
        end
        if (rd_issue) begin
          if (rd_issue_num == 3'd0 || e_tfull) merr = 1'b1;
          else tq.push_back(int'(rd_issue_num));
        end
        if (e_drop) merr = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rd_issue = 1'b0; rd_issue_num = 3'd0; dram_rsp_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] num);
    rd_issue = 1'b1; rd_issue_num = num; tick(); rd_issue = 1'b0;
  endtask

  task automatic do_reset();
    idle(); be_stall = 1'b0; n_rst = 1'b0; tick(); n_rst = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    checks += 10;
    if (sram_res_valid !== 1'b0) begin failures++; $display("FAIL %s_valid got=%0b exp=0", tag, sram_res_valid); end
    if (burst_complete !== 1'b0) begin failures++; $display("FAIL %s_bc got=%0b exp=0", tag, burst_complete); end
    if (rsp_sub_id !== 3'd0) begin failures++; $display("FAIL %s_sub got=%0d exp=0", tag, rsp_sub_id); end
    if (rsp_err !== 1'b0) begin failures++; $display("FAIL %s_err got=%0b exp=0", tag, rsp_err); end
    if (rsp_queue_full !== 1'b0) begin failures++; $display("FAIL %s_qfull got=%0b exp=0", tag, rsp_queue_full); end
    if (burst_track_full !== 1'b0) begin failures++; $display("FAIL %s_tfull got=%0b exp=0", tag, burst_track_full); end
    if (dram_rsp_ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%0b exp=1", tag, dram_rsp_ready); end
    if (be_dram_rd_req_complete !== 1'b1) begin failures++; $display("FAIL %s_complete got=%0b exp=1", tag, be_dram_rd_req_complete); end
    if (sram_rdata !== 32'd0) begin failures++; $display("FAIL %s_rdata got=%h exp=0", tag, sram_rdata); end
    if (rsp_id !== 8'd0) begin failures++; $display("FAIL %s_id got=%h exp=0", tag, rsp_id); end
  endtask

  task automatic test_reset();
    idle(); be_stall = 1'b0; dram_rsp_id = 8'd0; dram_rsp_rdata = 32'd0;
    n_rst = 1'b1; #1 n_rst = 1'b0; #2;
    check_reset_values("reset");
    tick(); tick(); n_rst = 1'b1;
  endtask

  task automatic test_single_burst();
    logic [31:0] d[4];
    int seen = 0;
    do_reset();
    issue(3'd4);
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    for (int c = 0; c < 10; c++) begin
      dram_rsp_valid = (c < 4); dram_rsp_id = 8'h12;
      if (c < 4) dram_rsp_rdata = d[c];
      @(negedge clk);
      if (sram_res_valid && seen < 4) begin
        checks += 4;
        if (rsp_sub_id !== 3'(seen)) begin failures++; $display("FAIL basic_sub got=%0d exp=%0d", rsp_sub_id, seen); end
        if (burst_complete !== (seen == 3)) begin failures++; $display("FAIL basic_bc got=%0b exp=%0b", burst_complete, seen == 3); end
        if (sram_rdata !== d[seen]) begin failures++; $display("FAIL basic_data got=%h exp=%h", sram_rdata, d[seen]); end
        if (rsp_id !== 8'h12) begin failures++; $display("FAIL basic_id got=%h exp=12", rsp_id); end
        seen++;
      end
      tick();
    end
    checks += 2;
    if (seen != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", seen); end
    if (be_dram_rd_req_complete !== 1'b1) begin failures++; $display("FAIL basic_complete got=%0b exp=1", be_dram_rd_req_complete); end
  endtask

  task automatic test_full_queue();
    logic [31:0] d[8];
    do_reset();
    issue(3'd4); issue(3'd4);
    be_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d[i] = $urandom; dram_rsp_valid = 1'b1; dram_rsp_id = 8'(i); dram_rsp_rdata = d[i]; tick();
    end
    dram_rsp_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (rsp_queue_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%0b exp=1", rsp_queue_full); end
    if (dram_rsp_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", dram_rsp_ready); end
    tick(); be_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks += 3;
      if (sram_res_valid !== 1'b1) begin failures++; $display("FAIL drain_valid beat=%0d got=%0b exp=1", i, sram_res_valid); end
      if (sram_rdata !== d[i]) begin failures++; $display("FAIL drain_order beat=%0d got=%h exp=%h", i, sram_rdata, d[i]); end
      if (dram_rsp_ready !== (i != 0)) begin failures++; $display("FAIL drain_ready beat=%0d got=%0b exp=%0b", i, dram_rsp_ready, i != 0); end
      tick();
    end
  endtask

  task automatic test_orphan_beat();
    do_reset();
    dram_rsp_valid = 1'b1; dram_rsp_id = 8'h33; dram_rsp_rdata = $urandom; tick();
    dram_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 3;
      if (rsp_err !== 1'b1) begin failures++; $display("FAIL orphan_err cyc=%0d got=%0b exp=1", i, rsp_err); end
      if (sram_res_valid !== 1'b0) begin failures++; $display("FAIL orphan_valid got=%0b exp=0", sram_res_valid); end
      if (be_dram_rd_req_complete !== 1'b1) begin failures++; $display("FAIL orphan_complete got=%0b exp=1", be_dram_rd_req_complete); end
      tick();
    end
  endtask

  task automatic test_tracker_full();
    do_reset();
    for (int i = 0; i < 4; i++) issue(3'd1);
    @(negedge clk);
    checks += 2;
    if (burst_track_full !== 1'b1) begin failures++; $display("FAIL tfull_flag got=%0b exp=1", burst_track_full); end
    if (rsp_err !== 1'b0) begin failures++; $display("FAIL tfull_err_early got=%0b exp=0", rsp_err); end
    tick();
    dram_rsp_valid = 1'b1; dram_rsp_id = 8'h44; dram_rsp_rdata = $urandom;
`ifndef DRAM_RSP_BYPASS_EN
    tick(); dram_rsp_valid = 1'b0;
`endif
    rd_issue = 1'b1; rd_issue_num = 3'd3;
    @(negedge clk);
    checks += 1;
    if (burst_complete !== 1'b1) begin failures++; $display("FAIL tfull_coincide got=%0b exp=1", burst_complete); end
    tick(); idle();
    @(negedge clk);
    checks += 2;
    if (rsp_err !== 1'b1) begin failures++; $display("FAIL tfull_err got=%0b exp=1", rsp_err); end
    if (burst_track_full !== 1'b0) begin failures++; $display("FAIL tfull_after got=%0b exp=0", burst_track_full); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bit done = 1'b0;
    do_reset();
    issue(3'd5);
    for (int i = 0; i < 2; i++) begin
      dram_rsp_valid = 1'b1; dram_rsp_id = 8'h55; dram_rsp_rdata = $urandom; tick();
    end
    #2 n_rst = 1'b0; #1;
    check_reset_values("midrst");
    tick(); idle(); n_rst = 1'b1;
    issue(3'd1);
    dram_rsp_valid = 1'b1; dram_rsp_id = 8'h66; dram_rsp_rdata = $urandom; tick();
    dram_rsp_valid = 1'b0;
    for (int c = 0; c < 4 && !done; c++) begin
      @(negedge clk);
      if (burst_complete) begin
        done = 1'b1;
        checks += 1;
        if (rsp_sub_id !== 3'd0) begin failures++; $display("FAIL midrst_sub got=%0d exp=0", rsp_sub_id); end
      end
      tick();
    end
    checks += 2;
    if (!done) begin failures++; $display("FAIL midrst_timeout got=no_completion exp=completion"); end
    if (be_dram_rd_req_complete !== 1'b1) begin failures++; $display("FAIL midrst_complete got=%0b exp=1", be_dram_rd_req_complete); end
  endtask

  task automatic test_latency();
    do_reset();
    issue(3'd1);
    dram_rsp_valid = 1'b1; dram_rsp_id = 8'h77; dram_rsp_rdata = $urandom;
    @(negedge clk);
    checks += 1;
    if (sram_res_valid !== BYP) begin failures++; $display("FAIL latency_same got=%0b exp=%0b", sram_res_valid, BYP); end
    tick(); dram_rsp_valid = 1'b0;
    @(negedge clk);
    checks += 1;
    if (sram_res_valid !== !BYP) begin failures++; $display("FAIL latency_next got=%0b exp=%0b", sram_res_valid, !BYP); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rd_issue = ($urandom_range(0, 3) == 0);
      rd_issue_num = 3'($urandom_range(0, 7));
      dram_rsp_valid = $urandom_range(0, 1);
      dram_rsp_id = 8'($urandom); dram_rsp_rdata = $urandom;
      be_stall = ($urandom_range(0, 9) < 3);
      tick();
    end
    idle(); be_stall = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    @(negedge clk);
    checks += 2;
    if (sram_res_valid !== 1'b0) begin failures++; $display("FAIL rand_drain_valid got=%0b exp=0", sram_res_valid); end
    if (dram_rsp_ready !== 1'b1) begin failures++; $display("FAIL rand_drain_ready got=%0b exp=1", dram_rsp_ready); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_full_queue();
    test_orphan_beat();
    test_tracker_full();
    test_reset_mid_burst();
    test_latency();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_rsp_queue.md
DRAM_RSP_QUEUE -- requirements
Module: dram_rsp_queue

Interface
REQ-001 Parameter RSP_DEPTH, default 8, response data FIFO depth; power of 2, at least 2.
REQ-002 Parameter MAX_BURSTS, default 4, burst-length tracker depth; power of 2, at least 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 n_rst  input  1  reset; asynchronous, active-low.
REQ-005 rd_issue  input  1  pulse: one DRAM read burst accepted by the DRAM controller.
REQ-006 rd_issue_num  input  3  beats expected for the issued burst; legal range 1..7.
REQ-007 dram_rsp_valid  input  1  DRAM read beat valid.
REQ-008 dram_rsp_id  input  DRAM_ID_WIDTH  transaction id of the beat.
REQ-009 dram_rsp_rdata  input  scpad_data_t  beat data.
REQ-010 dram_rsp_ready  output  1  beat accepted when valid and ready are both high.
REQ-011 be_stall  input  1  backend cannot take a beat this cycle.
REQ-012 sram_res_valid  output  1  beat delivered to the scratchpad backend this cycle.
REQ-013 sram_rdata  output  scpad_data_t  delivered beat data.
REQ-014 rsp_id  output  DRAM_ID_WIDTH  id of the delivered beat.
REQ-015 rsp_sub_id  output  3  beat index within the current burst, starting at 0.
REQ-016 burst_complete  output  1  one-cycle pulse coincident with the last beat of a burst.
REQ-017 be_dram_rd_req_complete  output  1  high when no bursts are tracked and the FIFO is empty.
REQ-018 rsp_queue_full  output  1  data FIFO holds RSP_DEPTH entries.
REQ-019 burst_track_full  output  1  tracker holds MAX_BURSTS lengths; requester shall not issue.
REQ-020 rsp_err  output  1  sticky protocol-error flag.

Function
REQ-021 dram_rsp_ready = !rsp_queue_full; a beat accepted while the tracker is non-empty is pushed as {id, data} into the in-order FIFO.
REQ-022 A beat accepted while no burst is tracked is dropped and sets rsp_err.
REQ-023 rd_issue with rd_issue_num in 1..7 and tracker not full pushes the length into the tracker FIFO.
REQ-024 rd_issue with rd_issue_num = 0 is dropped and sets rsp_err.
REQ-025 rd_issue while burst_track_full is dropped and sets rsp_err, even if a burst completes in the same cycle.
REQ-026 sram_res_valid = FIFO non-empty && !be_stall; each asserted cycle pops exactly one entry.
REQ-027 sram_rdata and rsp_id always show the FIFO head.
REQ-028 Beat counter drives rsp_sub_id and increments on each delivered beat.
REQ-029 On a delivered beat with counter = head length - 1: assert burst_complete, pop the tracker, clear the counter.
REQ-030 Simultaneous push and pop is legal in both FIFOs; occupancy is unchanged.
REQ-031 Pointers are log2(depth)+1 bits and wrap modulo 2×depth; full and empty derive from the MSB comparison.
REQ-032 Without bypass, minimum latency from accepted beat to sram_res_valid is 1 cycle; ordering is strict FIFO.
REQ-033 be_stall holds all outputs and the counter; no beat is lost or duplicated.

Reset
REQ-034 n_rst low immediately clears both FIFOs, the beat counter and rsp_err, discarding in-flight data.
REQ-035 Output values in reset: sram_res_valid=0, burst_complete=0, rsp_sub_id=0, rsp_err=0, rsp_queue_full=0, burst_track_full=0, dram_rsp_ready=1, be_dram_rd_req_complete=1, sram_rdata=0, rsp_id=0.

Configuration
REQ-036 Macro DRAM_RSP_BYPASS_EN.
- Defined: when the FIFO is empty, !be_stall, and a tracked beat is accepted, that beat is delivered in the same cycle with no FIFO write (0-cycle latency).
- Undefined: every beat passes through the FIFO (REQ-032); no combinational path from the dram_rsp_* inputs to the sram_* outputs.

Verification
REQ-037 Issue num=4; send 4 beats id=0x12 with no stall -> 4 sram_res_valid with sub_id 0,1,2,3; burst_complete only on sub_id 3; then be_dram_rd_req_complete=1.
REQ-038 be_stall=1; push 8 beats (RSP_DEPTH=8) -> rsp_queue_full=1 and dram_rsp_ready=0; release stall -> 8 beats in order; ready returns the cycle after the first pop.
REQ-039 Beat arrives with no burst issued -> beat dropped, rsp_err=1 and stays 1 until reset.
REQ-040 Issue 4 bursts (MAX_BURSTS=4), then a 5th issue in the same cycle as a completion -> 5th dropped, rsp_err=1.
REQ-041 Reset asserted mid-burst after 2 of 5 beats -> all outputs take their REQ-035 values immediately; a post-reset burst of num=1 completes normally.
REQ-042 Bypass: with DRAM_RSP_BYPASS_EN, empty FIFO, one beat -> sram_res_valid in the same cycle; without the macro -> sram_res_valid one cycle later.
